// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the ID/EX stage: decoded bundle layout,
// bubble constructor and the ID/EX hazard state encoding.
package pipeline_pkg;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;
   localparam int EN_W  = 4;

   // Bit positions inside the Enable vector of the decoded bundle.
   localparam int IDX_RD     = 0;  // writes rd
   localparam int IDX_MEM_RD = 1;  // load
   localparam int IDX_MEM_WR = 2;  // store
   localparam int IDX_BRANCH = 3;  // branch / jump

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  imm;
      logic [3:0]       alu_op;
      logic [EN_W-1:0]  enable;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
   } IDEX_Pipe_t;

   typedef enum logic {ST_RUN, ST_BUBBLE} idex_state_e;

   // A bubble only needs Enable and the register indices cleared, but the
   // whole bundle is zeroed so EX never sees stale data on a killed slot.
   function automatic IDEX_Pipe_t idex_bubble();
      IDEX_Pipe_t b;
      b = '0;
      return b;
   endfunction

endpackage

// File: rtl/hazard_perf_ctr.sv
// Free-running wrap-around event counter used for stall/flush statistics.
module hazard_perf_ctr #(
   parameter int PERF_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   output logic [PERF_W-1:0] value
);

   // Count one per qualifying edge; wraps modulo 2^PERF_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (inc) begin
         value <= value + PERF_W'(1);
      end
   end

endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash,
// protocol-violation detection and optional stall/flush counters.
// Optional feature: define IDEX_PERF_CNT_EN to build the counters;
// otherwise stall_cnt/flush_cnt are constant zero.
module idex_hazard_reg
   import pipeline_pkg::*;
#(
   parameter int PERF_W     = 64,
   parameter bit STICKY_ERR = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  IDEX_Pipe_t        idex_in,
   input  logic              id_valid,
   input  logic              stall,
   input  logic              flush,
   output IDEX_Pipe_t        idex_out,
   output logic              ex_valid,
   output logic              front_hold,
   output logic              bubble,
   output logic              proto_err,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
);

   idex_state_e state, state_nxt;
   IDEX_Pipe_t  out_nxt;
   logic        valid_nxt;
   logic        bubble_nxt;
   logic        violation;
   logic        stall_eff;

   // A flush overrides the stall: the stalled ID instruction is being
   // squashed anyway, so the front end is free to take the redirect.
   assign stall_eff  = stall & ~flush;
   assign front_hold = stall_eff & ~rst;

   // Next-state / next-bundle selection in priority flush > stall > normal.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_nxt  = ST_RUN;
      out_nxt    = idex_bubble();
      valid_nxt  = 1'b0;
      bubble_nxt = 1'b0;
      violation  = 1'b0;

      if (flush) begin
         // Squash: bubble in EX, but it is not a stall bubble.
         state_nxt = ST_RUN;
      end else if (stall) begin
         state_nxt  = ST_BUBBLE;
         bubble_nxt = 1'b1;
         // The load already left EX; a repeat stall means the detector
         // failed to see our bubble. Still insert a bubble to stay safe.
         violation  = (state == ST_BUBBLE);
      end else if (id_valid) begin
         out_nxt   = idex_in;
         valid_nxt = 1'b1;
      end
   end

   // Pipeline register and hazard state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state    <= ST_RUN;
         idex_out <= idex_bubble();
         ex_valid <= 1'b0;
         bubble   <= 1'b0;
      end else begin
         state    <= state_nxt;
         idex_out <= out_nxt;
         ex_valid <= valid_nxt;
         bubble   <= bubble_nxt;
      end
   end

   // Protocol error flag: sticky until reset, or a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err <= 1'b0;
      end else if (STICKY_ERR) begin
         proto_err <= proto_err | violation;
      end else begin
         proto_err <= violation;
      end
   end

`ifdef IDEX_PERF_CNT_EN
   hazard_perf_ctr #(.PERF_W(PERF_W)) u_stall_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_eff),
      .value (stall_cnt)
   );

   hazard_perf_ctr #(.PERF_W(PERF_W)) u_flush_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush),
      .value (flush_cnt)
   );
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Self-checking bench for idex_hazard_reg: directed vector table, hand-written
// wrap sequence, and randomized stimulus against a behavioural model.
// Two instances run in lockstep: sticky and pulsed proto_err.
module tb_idex_hazard_reg;
   import pipeline_pkg::*;

   localparam int PERF_W = 4;
   localparam int CNT_MOD = 1 << PERF_W;

   logic              clk = 1'b0;
   logic              rst, id_valid, stall, flush;
   IDEX_Pipe_t        idex_in;
   IDEX_Pipe_t        idex_out, idex_out_p;
   logic              ex_valid, ex_valid_p;
   logic              front_hold, front_hold_p;
   logic              bubble, bubble_p;
   logic              proto_err, proto_err_p;
   logic [PERF_W-1:0] stall_cnt, flush_cnt, stall_cnt_p, flush_cnt_p;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   idex_hazard_reg #(.PERF_W(PERF_W), .STICKY_ERR(1'b1)) dut (
      .clk(clk), .rst(rst), .idex_in(idex_in), .id_valid(id_valid),
      .stall(stall), .flush(flush), .idex_out(idex_out), .ex_valid(ex_valid),
      .front_hold(front_hold), .bubble(bubble), .proto_err(proto_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   idex_hazard_reg #(.PERF_W(PERF_W), .STICKY_ERR(1'b0)) dut_p (
      .clk(clk), .rst(rst), .idex_in(idex_in), .id_valid(id_valid),
      .stall(stall), .flush(flush), .idex_out(idex_out_p), .ex_valid(ex_valid_p),
      .front_hold(front_hold_p), .bubble(bubble_p), .proto_err(proto_err_p),
      .stall_cnt(stall_cnt_p), .flush_cnt(flush_cnt_p)
   );

   // ---------------- behavioural reference model ----------------
   IDEX_Pipe_t m_out;
   bit         m_valid, m_bubble, m_err_s, m_err_p;
   int         m_stall_cnt, m_flush_cnt;

   task automatic model_edge(input bit r, s, f, v, input IDEX_Pipe_t in);
      bit viol;
      if (r) begin
         m_out = '0; m_valid = 0; m_bubble = 0; m_err_s = 0; m_err_p = 0;
         m_stall_cnt = 0; m_flush_cnt = 0;
      end else begin
         // Violation: stall requested right after a stall bubble was inserted.
         viol = s && !f && m_bubble;
`ifdef IDEX_PERF_CNT_EN
         if (s && !f) m_stall_cnt = (m_stall_cnt + 1) % CNT_MOD;
         if (f)       m_flush_cnt = (m_flush_cnt + 1) % CNT_MOD;
`endif
         if (f) begin
            m_out = '0; m_valid = 0; m_bubble = 0;
         end else if (s) begin
            m_out = '0; m_valid = 0; m_bubble = 1;
         end else begin
            m_out = v ? in : IDEX_Pipe_t'('0);
            m_valid = v; m_bubble = 0;
         end
         m_err_s = m_err_s | viol;
         m_err_p = viol;
      end
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         rst, stall, flush, valid;
      IDEX_Pipe_t in;
      bit         fh, ev, bub, err_s, err_p;
      IDEX_Pipe_t out;
   } vec_t;

   function automatic vec_t mk(bit r, s, f, v, IDEX_Pipe_t in,
                               bit fh, ev, bub, es, ep, IDEX_Pipe_t out);
      vec_t t;
      t.rst = r; t.stall = s; t.flush = f; t.valid = v; t.in = in;
      t.fh = fh; t.ev = ev; t.bub = bub; t.err_s = es; t.err_p = ep; t.out = out;
      return t;
   endfunction

   // Apply one cycle; directed rows are compared against the table as well
   // as against the model, random rows only against the model.
   task automatic step(input vec_t t, input bit directed);
      rst = t.rst; stall = t.stall; flush = t.flush; id_valid = t.valid; idex_in = t.in;
      #1;
      check("front_hold", 128'(front_hold), 128'(!t.rst && t.stall && !t.flush));
      check("front_hold_p", 128'(front_hold_p), 128'(!t.rst && t.stall && !t.flush));
      if (directed) check("tbl_front_hold", 128'(front_hold), 128'(t.fh));
      @(posedge clk);
      model_edge(t.rst, t.stall, t.flush, t.valid, t.in);
      #1;
      check("idex_out", 128'(idex_out), 128'(m_out));
      check("ex_valid", 128'(ex_valid), 128'(m_valid));
      check("bubble", 128'(bubble), 128'(m_bubble));
      check("proto_err_sticky", 128'(proto_err), 128'(m_err_s));
      check("proto_err_pulse", 128'(proto_err_p), 128'(m_err_p));
      check("idex_out_p", 128'(idex_out_p), 128'(m_out));
      check("stall_cnt", 128'(stall_cnt), 128'(m_stall_cnt));
      check("flush_cnt", 128'(flush_cnt), 128'(m_flush_cnt));
      if (directed) begin
         check("tbl_idex_out", 128'(idex_out), 128'(t.out));
         check("tbl_ex_valid", 128'(ex_valid), 128'(t.ev));
         check("tbl_bubble", 128'(bubble), 128'(t.bub));
         check("tbl_err_sticky", 128'(proto_err), 128'(t.err_s));
         check("tbl_err_pulse", 128'(proto_err_p), 128'(t.err_p));
      end
   endtask

   initial begin
      IDEX_Pipe_t ld, add, garb, z;
      vec_t tbl[14];
      vec_t rv;
      logic [95:0] rbits;
      int exp_wrap;

      z = '0;
      ld = '0;   ld.pc = 32'h0;  ld.imm = 32'h8; ld.rd = 5'd5; ld.rs1 = 5'd2;
      ld.enable[IDX_RD] = 1'b1;  ld.enable[IDX_MEM_RD] = 1'b1;
      add = '0;  add.pc = 32'h4; add.rd = 5'd6; add.rs1 = 5'd5; add.rs2 = 5'd1;
      add.alu_op = 4'h1; add.enable[IDX_RD] = 1'b1;
      garb = '0; garb.pc = 32'hdead_beef; garb.imm = 32'h1234_5678; garb.alu_op = 4'hf;
      garb.enable = '1; garb.rd = 5'd31; garb.rs1 = 5'd17; garb.rs2 = 5'd9;

      //           rst s f v  in    fh ev bub es ep out
      tbl[0]  = mk(1, 1, 1, 1, ld,   0, 0, 0, 0, 0, z);    // reset with stall+flush
      tbl[1]  = mk(1, 1, 1, 1, ld,   0, 0, 0, 0, 0, z);
      tbl[2]  = mk(0, 0, 0, 1, ld,   0, 1, 0, 0, 0, ld);   // load enters EX
      tbl[3]  = mk(0, 1, 0, 1, add,  1, 0, 1, 0, 0, z);    // load-use stall
      tbl[4]  = mk(0, 0, 0, 1, add,  0, 1, 0, 0, 0, add);  // add follows
      tbl[5]  = mk(0, 1, 1, 1, add,  0, 0, 0, 0, 0, z);    // flush beats stall
      tbl[6]  = mk(0, 0, 0, 0, garb, 0, 0, 0, 0, 0, z);    // invalid ID -> bubble
      tbl[7]  = mk(0, 1, 0, 1, add,  1, 0, 1, 0, 0, z);
      tbl[8]  = mk(0, 1, 0, 1, add,  1, 0, 1, 1, 1, z);    // second stall: violation
      tbl[9]  = mk(0, 0, 0, 1, add,  0, 1, 0, 1, 0, add);  // sticky holds, pulse drops
      tbl[10] = mk(0, 1, 0, 1, ld,   1, 0, 1, 1, 0, z);    // legal stall from RUN
      tbl[11] = mk(1, 1, 0, 1, ld,   0, 0, 0, 0, 0, z);    // reset mid-stall
      tbl[12] = mk(0, 1, 0, 1, ld,   1, 0, 1, 0, 0, z);    // no violation after reset
      tbl[13] = mk(0, 0, 0, 1, ld,   0, 1, 0, 0, 0, ld);

      for (int i = 0; i < 14; i++) step(tbl[i], 1'b1);

      // Counter wrap: 17 flushes after reset.
      rv = mk(1, 0, 0, 0, z, 0, 0, 0, 0, 0, z);
      step(rv, 1'b0);
      for (int i = 0; i < 17; i++) begin
         rv = mk(0, (i % 3) == 0, 1, 1, add, 0, 0, 0, 0, 0, z);
         step(rv, 1'b0);
      end
`ifdef IDEX_PERF_CNT_EN
      exp_wrap = 1;
`else
      exp_wrap = 0;
`endif
      check("flush_cnt_wrap", 128'(flush_cnt), 128'(exp_wrap));
      check("stall_cnt_after_flushes", 128'(stall_cnt), 128'(0));

      // Randomized stimulus against the model.
      for (int i = 0; i < 500; i++) begin
         rbits = {$urandom(), $urandom(), $urandom()};
         rv = mk($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 75,
                 IDEX_Pipe_t'(rbits[$bits(IDEX_Pipe_t)-1:0]), 0, 0, 0, 0, 0, z);
         step(rv, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
